// File: rtl/deint_mem_dpath_if.sv
// Bus between the deinterleaver data path and its environment: address-generator
// strobes, upstream symbol handshake, SRAM data lines and the downstream FIFO port.
interface deint_mem_dpath_if #(
    parameter int DW = 8
);
    logic          en_in;
    logic          nwrt;
    logic          nce;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_sync;
    logic          underrun;
    logic          overflow;

    modport slave (
        input  en_in, nwrt, nce, din, din_valid, mem_rdata, dout_ready,
        output din_ready, mem_wdata, dout, dout_valid, dout_sync, underrun, overflow
    );

    modport master (
        output en_in, nwrt, nce, din, din_valid, mem_rdata, dout_ready,
        input  din_ready, mem_wdata, dout, dout_valid, dout_sync, underrun, overflow
    );
endinterface

// File: rtl/deint_mem_dpath.sv
// Deinterleaver SRAM data path: write-data holding register, read capture with
// initial flush, and a small first-word-fall-through output FIFO with packet sync.
module deint_mem_dpath #(
    parameter int DW          = 8,
    parameter int FLUSH_SYMS  = 12288,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_PERIOD = 204
) (
    input  logic              clk,
    input  logic              rst,
    deint_mem_dpath_if.slave  bus
);
    localparam int FW = $clog2(FLUSH_SYMS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(SYNC_PERIOD);
    localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_SYMS);
    localparam logic [CW-1:0] FIFO_MAX  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);

    logic          r_hold_full;
    logic [DW-1:0] r_hold;
    logic          r_rd_pend;
    logic [FW-1:0] r_flush_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_sync_cnt;
    logic          r_underrun;
    logic          r_overflow;
    logic [DW-1:0] r_mem [FIFO_DEPTH];

    logic w_wr_cyc;
    logic w_rd_cyc;
    logic w_load;
    logic w_flush_done;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_accept;

    assign w_wr_cyc     = ~bus.nce & ~bus.nwrt;
    assign w_rd_cyc     = ~bus.nce &  bus.nwrt;
    assign w_load       = bus.din_valid & ~r_hold_full;
    assign w_flush_done = (r_flush_cnt == FLUSH_MAX);
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FIFO_MAX);
    assign w_push       = bus.en_in & r_rd_pend & w_flush_done;
    assign w_pop        = ~w_empty & w_flush_done & bus.dout_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_accept     = w_push & (~w_full | w_pop);

    assign bus.din_ready  = ~r_hold_full;
    assign bus.mem_wdata  = (w_wr_cyc && r_hold_full) ? r_hold : '0;
    assign bus.dout       = r_mem[r_rptr];
    assign bus.dout_valid = ~w_empty & w_flush_done;
    assign bus.dout_sync  = bus.dout_valid & (r_sync_cnt == '0);
    assign bus.underrun   = r_underrun;
    assign bus.overflow   = r_overflow;

    // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold      <= '0;
        end else if (!bus.en_in) begin
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b1;
            r_hold      <= bus.din;
        end else if (w_wr_cyc) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend   <= 1'b0;
            r_flush_cnt <= '0;
        end else if (!bus.en_in) begin
            r_rd_pend   <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_rd_pend <= w_rd_cyc;
            if (r_rd_pend && !w_flush_done)
                r_flush_cnt <= r_flush_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_sync_cnt <= '0;
        end else if (!bus.en_in) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_sync_cnt <= '0;
        end else begin
            if (w_accept)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_rptr     <= r_rptr + AW'(1);
                r_sync_cnt <= (r_sync_cnt == SYNC_LAST) ? '0 : r_sync_cnt + SW'(1);
            end
            if (w_accept && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_accept && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    // NOTE: the storage array is not reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wptr] <= bus.mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_cyc && !r_hold_full)
                r_underrun <= 1'b1;
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_deint_mem_dpath.sv
// Randomised self-checking bench for deint_mem_dpath against a transaction-level
// model: SRAM array, scoreboard FIFO queue and in-flight read queue.
module tb_deint_mem_dpath;
    localparam int DW    = 8;
    localparam int FLUSH = 12288;
    localparam int DEPTH = 4;
    localparam int SYNC  = 204;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } arrival_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deint_mem_dpath_if #(.DW(DW)) bus ();

    deint_mem_dpath #(
        .DW(DW), .FLUSH_SYMS(FLUSH), .FIFO_DEPTH(DEPTH), .SYNC_PERIOD(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] sram [256];
    logic [DW-1:0] fifo_q [$];
    arrival_t      arr_q [$];
    logic          m_hold_full;
    logic [DW-1:0] m_hold;
    int            m_reads;
    int            m_pops;
    logic          m_under;
    logic          m_over;
    int            cyc;
    logic [DW-1:0] ramp;
    logic [7:0]    addr;
    int            valid_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit en, input bit ce_n, input bit wr_n, input bit dv,
                        input bit rdy, input logic [7:0] a);
        logic          wr;
        logic          rd;
        logic          pop;
        logic [DW-1:0] exp_wdata;
        arrival_t      ar;
        bus.en_in      = en;
        bus.nce        = ce_n;
        bus.nwrt       = wr_n;
        bus.din_valid  = dv;
        bus.din        = ramp;
        bus.dout_ready = rdy;
        wr = !ce_n && !wr_n;
        rd = !ce_n &&  wr_n;
        #1;
        exp_wdata = (wr && m_hold_full) ? m_hold : '0;
        check("mem_wdata", bus.mem_wdata, exp_wdata);
        check("din_ready", bus.din_ready, !m_hold_full);
        @(posedge clk);
        #1;
        cyc++;
        if (wr && !m_hold_full) m_under = 1'b1;
        if (!en) begin
            fifo_q.delete();
            arr_q.delete();
            m_hold_full = 1'b0;
            m_reads     = 0;
            m_pops      = 0;
        end else begin
            pop = (fifo_q.size() > 0) && rdy;
            if (pop) begin
                void'(fifo_q.pop_front());
                m_pops++;
            end
            if (arr_q.size() > 0 && arr_q[0].due == cyc) begin
                ar = arr_q.pop_front();
                if (fifo_q.size() < DEPTH) fifo_q.push_back(ar.d);
                else m_over = 1'b1;
            end
            if (rd) begin
                m_reads++;
                bus.mem_rdata = sram[a];
                if (m_reads > FLUSH) begin
                    ar.due = cyc + 1;
                    ar.d   = sram[a];
                    arr_q.push_back(ar);
                end
            end
            if (wr) sram[a] = exp_wdata;
            if (dv && !m_hold_full) begin
                m_hold_full = 1'b1;
                m_hold      = ramp;
                ramp        = ramp + 8'd1;
            end else if (wr) begin
                m_hold_full = 1'b0;
            end
        end
        @(negedge clk);
        check("dout_valid", bus.dout_valid, fifo_q.size() > 0);
        if (fifo_q.size() > 0) begin
            check("dout", bus.dout, fifo_q[0]);
            check("dout_sync", bus.dout_sync, (m_pops % SYNC) == 0);
        end else begin
            check("dout_sync_idle", bus.dout_sync, 1'b0);
        end
        check("underrun", bus.underrun, m_under);
        check("overflow", bus.overflow, m_over);
        if (bus.dout_valid) valid_seen++;
    endtask

    task automatic pair(input bit dv, input bit rdy);
        step(1'b1, 1'b0, 1'b0, dv, rdy, addr);
        step(1'b1, 1'b0, 1'b1, dv, rdy, addr);
        addr = addr + 8'd1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = '0;
        m_hold_full = 1'b0;
        m_hold = '0;
        m_reads = 0;
        m_pops = 0;
        m_under = 1'b0;
        m_over = 1'b0;
        cyc = 0;
        ramp = 8'h5A;
        addr = 8'd0;
        valid_seen = 0;
        bus.en_in = 1'b0;
        bus.nce = 1'b1;
        bus.nwrt = 1'b1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.mem_rdata = '0;
        bus.dout_ready = 1'b0;

        // Reset state
        #3;
        check("rst_din_ready", bus.din_ready, 1'b1);
        check("rst_dout_valid", bus.dout_valid, 1'b0);
        check("rst_dout_sync", bus.dout_sync, 1'b0);
        check("rst_mem_wdata", bus.mem_wdata, 8'h00);
        check("rst_underrun", bus.underrun, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Flush: the first FLUSH reads are discarded, the next appears 2 clk after its read cycle
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        valid_seen = 0;
        for (int i = 0; i < FLUSH; i++) pair(1'b1, 1'b1);
        check("flush_quiet", valid_seen, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, addr);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, addr);
        addr = addr + 8'd1;
        check("lat_rd_plus1", bus.dout_valid, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, addr);
        check("lat_rd_plus2_valid", bus.dout_valid, 1'b1);
        check("lat_rd_plus2_data", bus.dout, 8'(8'h5A + FLUSH));
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, addr);
        addr = addr + 8'd1;
        for (int i = 0; i < 3; i++) pair(1'b1, 1'b1);

        // Backpressure: fill to DEPTH, next capture overflows, then drain in order
        check("ovf_before", bus.overflow, 1'b0);
        for (int i = 0; i < 6; i++) pair(1'b1, 1'b0);
        check("ovf_set", bus.overflow, 1'b1);
        for (int i = 0; i < 6; i++) pair(1'b1, 1'b1);

        // Sync marking over a long streaming run
        for (int i = 0; i < 410; i++) pair(1'b1, 1'b1);

        // Underrun: a write cycle with the holding register empty
        check("under_before", bus.underrun, 1'b0);
        pair(1'b0, 1'b1);
        pair(1'b0, 1'b1);
        check("under_set", bus.underrun, 1'b1);
        for (int i = 0; i < 4; i++) pair(1'b1, 1'b1);
        check("under_sticky", bus.underrun, 1'b1);

        // Random traffic: idle gaps, upstream gaps, random downstream backpressure
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0)
                step(1'b1, 1'b1, 1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'd0);
            pair($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        // Enable drop with three entries held, then a full re-flush
        for (int k = 0; k < 20 && fifo_q.size() != 0; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        check("drain_empty", bus.dout_valid, 1'b0);
        for (int k = 0; k < 20 && fifo_q.size() < 3; k++) pair(1'b1, 1'b0);
        check("fill3_valid", bus.dout_valid, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        check("en_drop_valid", bus.dout_valid, 1'b0);
        check("en_drop_din_ready", bus.din_ready, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        valid_seen = 0;
        for (int i = 0; i < FLUSH; i++) pair(1'b1, 1'b1);
        check("reflush_quiet", valid_seen, 0);
        for (int i = 0; i < 3; i++) pair(1'b1, 1'b1);
        check("reflush_out", valid_seen > 0, 1'b1);

        // Asynchronous reset mid-stream with the FIFO half full
        for (int k = 0; k < 20 && fifo_q.size() != 0; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        for (int k = 0; k < 20 && fifo_q.size() < 2; k++) pair(1'b1, 1'b0);
        check("pre_rst_valid", bus.dout_valid, 1'b1);
        check("pre_rst_din_ready", bus.din_ready, 1'b0);
        check("pre_rst_flags", {bus.underrun, bus.overflow}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dout_valid", bus.dout_valid, 1'b0);
        check("arst_din_ready", bus.din_ready, 1'b1);
        check("arst_underrun", bus.underrun, 1'b0);
        check("arst_overflow", bus.overflow, 1'b0);
        check("arst_dout_sync", bus.dout_sync, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
